vga_timing_gen: RTL and testbench

//   Raster timing generator for the VGA display path. Sits directly downstream of the

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA display path.
// One clk edge with pix_en=1 moves the raster by one pixel. Every output is
// registered and decoded from the counter values loaded on that same edge, so
// x/y/hsync/vsync/video_on always describe the position currently held.
// After reset the counters sit on the last pixel of a frame. The first pix_en
// edge therefore starts a clean frame at (0,0).
// CW must be wide enough to hold H_TOTAL-1 and V_TOTAL-1.

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Level driven while inside a sync pulse, and the idle level outside it.
    localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_OFF = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          video_on_r;
    logic          line_start_r;
    logic          frame_start_r;

    logic [CW-1:0] h_nxt_s;
    logic [CW-1:0] v_nxt_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;
    logic          video_on_nxt_s;
    logic          line_start_nxt_s;
    logic          frame_start_nxt_s;

    // Next raster position: h wraps at the end of a line, and v advances only on that wrap.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_nxt_s = '0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + ONE;
            end
        end else begin
            h_nxt_s = h_cnt_r + ONE;
            v_nxt_s = v_cnt_r;
        end
    end

    // Decode region flags and pulses from the position about to be loaded.
    always_comb begin
        hsync_nxt_s       = SYNC_OFF;
        vsync_nxt_s       = SYNC_OFF;
        video_on_nxt_s    = 1'b0;
        line_start_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
        if ((h_nxt_s >= H_SYNC_BEG) && (h_nxt_s < H_SYNC_END)) begin
            hsync_nxt_s = SYNC_ON;
        end else begin
            hsync_nxt_s = SYNC_OFF;
        end
        if ((v_nxt_s >= V_SYNC_BEG) && (v_nxt_s < V_SYNC_END)) begin
            vsync_nxt_s = SYNC_ON;
        end else begin
            vsync_nxt_s = SYNC_OFF;
        end
        video_on_nxt_s    = (h_nxt_s < H_ACT_END) && (v_nxt_s < V_ACT_END);
        line_start_nxt_s  = (h_nxt_s == '0);
        frame_start_nxt_s = (h_nxt_s == '0) && (v_nxt_s == '0);
    end

    // Raster state and output registers. Without pix_en, everything holds except
    // the start pulses, which last exactly one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            hsync_r       <= SYNC_OFF;
            vsync_r       <= SYNC_OFF;
            video_on_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (pix_en) begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            video_on_r    <= video_on_nxt_s;
            line_start_r  <= line_start_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign x           = h_cnt_r;
    assign y           = v_cnt_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut   : default 640x480 timing, active-low sync.
// dut_p : default timing, active-high sync; shares all inputs with dut.
// dut_s : reduced geometry (15x9 total) so that whole frames fit in a short run.
//         It has its own pixel enable and shares rst with the other two.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic pix_en_s;

    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] x, y;

    logic       hsync_p, vsync_p, video_on_p, line_start_p, frame_start_p;
    logic [9:0] x_p, y_p;

    logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
    logic [9:0] x_s, y_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(.SYNC_POL(1)) dut_p (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(hsync_p), .vsync(vsync_p), .video_on(video_on_p),
        .x(x_p), .y(y_p), .line_start(line_start_p), .frame_start(frame_start_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .CW(10)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
        .x(x_s), .y(y_s), .line_start(line_start_s), .frame_start(frame_start_s)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk: drive enables at the falling edge, then sample 1 time unit after the rising edge.
    task automatic tick(input logic pe, input logic pes);
        @(negedge clk);
        pix_en   = pe;
        pix_en_s = pes;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    // First pix_en edge after reset: the frame starts at (0,0) with both pulses, which clear one clk later.
    task automatic first_frame_checks();
        tick(1'b1, 1'b0);
        check_eq("ff_x", x, 0);
        check_eq("ff_y", y, 0);
        check_eq("ff_video_on", video_on, 1);
        check_eq("ff_line_start", line_start, 1);
        check_eq("ff_frame_start", frame_start, 1);
        check_eq("ff_hsync", hsync, 1);
        check_eq("ff_vsync", vsync, 1);
        tick(1'b0, 1'b0);
        check_eq("ff_line_start_clr", line_start, 0);
        check_eq("ff_frame_start_clr", frame_start, 0);
        check_eq("ff_x_hold", x, 0);
    endtask

    initial begin
        int ls_cnt;
        int fs_cnt;
        int fs_first;
        int fs_second;
        int vs_low;
        int von_cnt;
        int von_bad;
        int frz_bad;

        rst      = 1'b1;
        pix_en   = 1'b0;
        pix_en_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check_eq("rst_x", x, 799);
        check_eq("rst_y", y, 524);
        check_eq("rst_video_on", video_on, 0);
        check_eq("rst_line_start", line_start, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_hsync", hsync, 1);
        check_eq("rst_vsync", vsync, 1);
        check_eq("rst_hsync_pol1", hsync_p, 0);
        check_eq("rst_vsync_pol1", vsync_p, 0);
        check_eq("rst_x_small", x_s, 14);
        check_eq("rst_y_small", y_s, 8);

        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        check_eq("rel_x_hold", x, 799);

        // Scenario 1.
        first_frame_checks();

        // Scenario 2 and the active-high variant: horizontal region boundaries.
        run(639);
        check_eq("h639_x", x, 639);
        check_eq("h639_video_on", video_on, 1);
        run(1);
        check_eq("h640_x", x, 640);
        check_eq("h640_video_on", video_on, 0);
        run(15);
        check_eq("h655_hsync", hsync, 1);
        check_eq("h655_hsync_pol1", hsync_p, 0);
        run(1);
        check_eq("h656_x", x, 656);
        check_eq("h656_hsync", hsync, 0);
        check_eq("h656_hsync_pol1", hsync_p, 1);
        run(95);
        check_eq("h751_hsync", hsync, 0);
        check_eq("h751_hsync_pol1", hsync_p, 1);
        run(1);
        check_eq("h752_x", x, 752);
        check_eq("h752_hsync", hsync, 1);
        check_eq("h752_hsync_pol1", hsync_p, 0);
        run(47);
        check_eq("h799_x", x, 799);
        check_eq("h799_y", y, 0);

        // Scenario 3: one full line starting from (799,0).
        run(1);
        check_eq("wrap_x", x, 0);
        check_eq("wrap_y", y, 1);
        check_eq("wrap_line_start", line_start, 1);
        check_eq("wrap_frame_start", frame_start, 0);
        ls_cnt = (line_start === 1'b1) ? 1 : 0;
        fs_cnt = (frame_start === 1'b1) ? 1 : 0;
        for (int i = 0; i < 799; i++) begin
            run(1);
            if (line_start === 1'b1) ls_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        check_eq("line_ls_count", ls_cnt, 1);
        check_eq("line_fs_count", fs_cnt, 0);
        check_eq("line_end_x", x, 799);
        check_eq("line_end_y", y, 1);

        // Scenario 4 on the reduced geometry: two full frames of 135 edges, with dut frozen.
        check_eq("small_hold_x", x_s, 14);
        check_eq("small_hold_y", y_s, 8);
        ls_cnt    = 0;
        fs_cnt    = 0;
        fs_first  = -1;
        fs_second = -1;
        vs_low    = 0;
        von_cnt   = 0;
        von_bad   = 0;
        for (int e = 1; e <= 270; e++) begin
            tick(1'b0, 1'b1);
            if (line_start_s === 1'b1) ls_cnt++;
            if (frame_start_s === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = e;
                else fs_second = e;
            end
            if (vsync_s === 1'b0) begin
                vs_low++;
                if ((y_s != 10'd6) && (y_s != 10'd7)) von_bad++;
            end
            if (video_on_s === 1'b1) begin
                von_cnt++;
                if ((y_s >= 10'd4) || (x_s >= 10'd8)) von_bad++;
            end
        end
        check_eq("frm_fs_count", fs_cnt, 2);
        check_eq("frm_fs_first", fs_first, 1);
        check_eq("frm_fs_gap", fs_second - fs_first, 135);
        check_eq("frm_ls_count", ls_cnt, 18);
        check_eq("frm_vsync_low", vs_low, 60);
        check_eq("frm_video_on", von_cnt, 64);
        check_eq("frm_region_bad", von_bad, 0);
        check_eq("frz4_x", x, 799);
        check_eq("frz4_y", y, 1);

        // Scenario 5: freeze at x=300 for 50 clks.
        run(301);
        check_eq("pre_frz_x", x, 300);
        check_eq("pre_frz_y", y, 2);
        frz_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0);
            if ((x !== 10'd300) || (y !== 10'd2) || (video_on !== 1'b1) ||
                (hsync !== 1'b1) || (vsync !== 1'b1) || (line_start !== 1'b0))
                frz_bad++;
        end
        check_eq("frz_bad_clks", frz_bad, 0);
        check_eq("frz_x", x, 300);
        check_eq("frz_video_on", video_on, 1);

        // Scenario 6: async reset between clk edges, then a clean restart.
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_x", x, 799);
        check_eq("arst_y", y, 524);
        check_eq("arst_video_on", video_on, 0);
        check_eq("arst_hsync", hsync, 1);
        check_eq("arst_hsync_pol1", hsync_p, 0);
        check_eq("arst_x_small", x_s, 14);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        first_frame_checks();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
